// File: rtl/plab4_net_domain_slot_sched_pkg.sv
// Shared definitions for the ring domain slot scheduler: FSM state encodings and domain ids.
// The TP router ctrls use the same domain constants.
package plab4_net_domain_slot_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DEAD   = 2'd2
    } sched_state_t;

    localparam logic DOMAIN_0 = 1'b0;
    localparam logic DOMAIN_1 = 1'b1;

endpackage

// File: rtl/plab4_net_domain_slot_sched_counter.sv
// Loadable down-counter for the slot scheduler.
// It saturates at zero; load takes priority over decrement.
module plab4_net_slot_counter #(
    parameter int p_len_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   dec,
    input  logic [p_len_nbits-1:0] load_val,
    output logic [p_len_nbits-1:0] cnt,
    output logic                   zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - p_len_nbits'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/plab4_net_domain_slot_sched.sv
// Time-division domain scheduler for the ring: fixed-length slots, alternating domain, dead tail.
// Optional per-domain slot counters are enabled with PLAB4_NET_DOMAIN_SCHED_STATS_EN.
module plab4_net_domain_slot_sched
    import plab4_net_domain_slot_sched_pkg::*;
#(
    parameter int p_len_nbits = 8,
    parameter int p_slot_len  = 16,
    parameter int p_dead_len  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   cfg_val,
    output logic                   cfg_rdy,
    input  logic [p_len_nbits-1:0] cfg_slot_len,
    input  logic [p_len_nbits-1:0] cfg_dead_len,
    output logic                   cfg_err,
    output logic                   domain,
    output logic                   inject_en,
    output logic                   slot_start,
    output logic [p_len_nbits-1:0] slot_cnt
`ifdef PLAB4_NET_DOMAIN_SCHED_STATS_EN
    ,
    output logic [15:0]            slots_d0,
    output logic [15:0]            slots_d1
`endif
);

    sched_state_t           state, state_n;
    logic                   dom_n, inj_n, new_slot, dec, zero, started;
    logic [p_len_nbits-1:0] l_reg, d_reg, pend_l, pend_d, eff_l, load_val;
    logic                   pend_vld, cfg_fire, cfg_legal;

    // A pending config takes effect on the very slot it starts.
    assign eff_l     = pend_vld ? pend_l : l_reg;
    assign load_val  = eff_l - p_len_nbits'(1);
    assign cfg_rdy   = !pend_vld;
    assign cfg_fire  = cfg_val && cfg_rdy;
    assign cfg_legal = (cfg_slot_len != '0) && (cfg_dead_len < cfg_slot_len);

    plab4_net_slot_counter #(.p_len_nbits(p_len_nbits)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (new_slot),
        .dec      (dec),
        .load_val (load_val),
        .cnt      (slot_cnt),
        .zero     (zero)
    );

    always_comb begin
        state_n  = state;
        dom_n    = domain;
        inj_n    = inject_en;
        new_slot = 1'b0;
        dec      = 1'b0;
        case (state)
            ST_IDLE: begin
                inj_n = 1'b0;
                if (en) begin
                    new_slot = 1'b1;
                    dom_n    = started ? ((domain == DOMAIN_0) ? DOMAIN_1 : DOMAIN_0) : DOMAIN_0;
                end
            end
            ST_ACTIVE, ST_DEAD: begin
                if (zero) begin
                    if (en) begin
                        new_slot = 1'b1;
                        dom_n    = (domain == DOMAIN_0) ? DOMAIN_1 : DOMAIN_0;
                    end else begin
                        state_n = ST_IDLE;
                        inj_n   = 1'b0;
                    end
                end else begin
                    dec = 1'b1;
                    if (state == ST_ACTIVE && d_reg != '0 && slot_cnt == d_reg) begin
                        state_n = ST_DEAD;
                        inj_n   = 1'b0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Legal configs guarantee D < L, so every slot opens with at least one ACTIVE cycle.
        if (new_slot) begin
            state_n = ST_ACTIVE;
            inj_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            domain     <= DOMAIN_0;
            inject_en  <= 1'b0;
            slot_start <= 1'b0;
            started    <= 1'b0;
        end else begin
            state      <= state_n;
            domain     <= dom_n;
            inject_en  <= inj_n;
            slot_start <= new_slot;
            if (new_slot)
                started <= 1'b1;
        end
    end

    // cfg_fire needs !pend_vld, so accept and apply never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_reg    <= p_len_nbits'(p_slot_len);
            d_reg    <= p_len_nbits'(p_dead_len);
            pend_l   <= '0;
            pend_d   <= '0;
            pend_vld <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_fire && !cfg_legal;
            if (new_slot && pend_vld) begin
                l_reg    <= pend_l;
                d_reg    <= pend_d;
                pend_vld <= 1'b0;
            end else if (cfg_fire && cfg_legal) begin
                pend_l   <= cfg_slot_len;
                pend_d   <= cfg_dead_len;
                pend_vld <= 1'b1;
            end
        end
    end

`ifdef PLAB4_NET_DOMAIN_SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slots_d0 <= '0;
            slots_d1 <= '0;
        end else if (new_slot) begin
            if (dom_n == DOMAIN_0)
                slots_d0 <= slots_d0 + 16'd1;
            else
                slots_d1 <= slots_d1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_plab4_net_domain_slot_sched.sv
// Scoreboard bench for plab4_net_domain_slot_sched: expected slot starts and cfg_err pulses are
// queued by the stimulus and matched by a negedge monitor; a few point checks cover inject_en.
module tb_plab4_net_domain_slot_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_val = 1'b0;
    logic       cfg_rdy;
    logic [7:0] cfg_slot_len = 8'd0;
    logic [7:0] cfg_dead_len = 8'd0;
    logic       cfg_err;
    logic       domain;
    logic       inject_en;
    logic       slot_start;
    logic [7:0] slot_cnt;
`ifdef PLAB4_NET_DOMAIN_SCHED_STATS_EN
    logic [15:0] slots_d0, slots_d1;
`endif

    plab4_net_domain_slot_sched #(.p_len_nbits(8), .p_slot_len(16), .p_dead_len(2)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .en           (en),
        .cfg_val      (cfg_val),
        .cfg_rdy      (cfg_rdy),
        .cfg_slot_len (cfg_slot_len),
        .cfg_dead_len (cfg_dead_len),
        .cfg_err      (cfg_err),
        .domain       (domain),
        .inject_en    (inject_en),
        .slot_start   (slot_start),
        .slot_cnt     (slot_cnt)
`ifdef PLAB4_NET_DOMAIN_SCHED_STATS_EN
        ,
        .slots_d0     (slots_d0),
        .slots_d1     (slots_d1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       dom;
        logic [7:0] cnt;
    } slot_exp_t;

    slot_exp_t sq[$];
    int        eq[$];
    int        n_chk = 0;
    int        n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic push_slot(input int at, input logic dom, input int cnt);
        slot_exp_t e;
        e.at  = at;
        e.dom = dom;
        e.cnt = 8'(cnt);
        sq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic send_cfg(input int l, input int d);
        cfg_slot_len = 8'(l);
        cfg_dead_len = 8'(d);
        cfg_val      = 1'b1;
        step();
        cfg_val      = 1'b0;
    endtask

    // Monitor: every slot_start / cfg_err pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (slot_start) begin
                if (sq.size() == 0) begin
                    chk("unexpected_slot_start", cyc, -1);
                end else begin
                    slot_exp_t e;
                    e = sq.pop_front();
                    chk("slot_start_cycle", cyc, e.at);
                    chk("slot_domain", int'(domain), int'(e.dom));
                    chk("slot_cnt_at_start", int'(slot_cnt), int'(e.cnt));
                end
            end
            if (cfg_err) begin
                if (eq.size() == 0) chk("unexpected_cfg_err", cyc, -1);
                else chk("cfg_err_cycle", cyc, eq.pop_front());
            end
        end
    end

    int c, r;

    initial begin
        step();
        step();
        chk("rst_domain", int'(domain), 0);
        chk("rst_inject_en", int'(inject_en), 0);
        chk("rst_slot_start", int'(slot_start), 0);
        chk("rst_slot_cnt", int'(slot_cnt), 0);
        chk("rst_cfg_rdy", int'(cfg_rdy), 1);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;
        step();

        // Defaults L=16, D=2
        c = cyc;
        push_slot(c + 1, 1'b0, 15);
        push_slot(c + 17, 1'b1, 15);
        push_slot(c + 33, 1'b0, 15);
        en = 1'b1;
        goto(c + 14);
        chk("inj_last_active", int'(inject_en), 1);
        chk("cnt_last_active", int'(slot_cnt), 2);
        goto(c + 15);
        chk("inj_dead0", int'(inject_en), 0);
        goto(c + 16);
        chk("inj_dead1", int'(inject_en), 0);
        chk("cnt_boundary", int'(slot_cnt), 0);
        goto(c + 17);
        chk("inj_next_slot", int'(inject_en), 1);

        // en dropped mid-slot: slot completes, then IDLE with domain held
        goto(c + 39);
        chk("cnt_at_en_drop", int'(slot_cnt), 9);
        en = 1'b0;
        goto(c + 48);
        chk("cnt_end_after_drop", int'(slot_cnt), 0);
        goto(c + 49);
        chk("idle_inject_en", int'(inject_en), 0);
        chk("idle_domain_held", int'(domain), 0);
        push_slot(c + 53, 1'b1, 15);
        goto(c + 52);
        en = 1'b1;

        // Legal config L=4, D=0 mid-slot
        goto(c + 56);
        chk("cfg_rdy_before", int'(cfg_rdy), 1);
        push_slot(c + 69, 1'b0, 3);
        push_slot(c + 73, 1'b1, 3);
        push_slot(c + 77, 1'b0, 3);
        push_slot(c + 81, 1'b1, 3);
        send_cfg(4, 0);
        chk("cfg_rdy_pending", int'(cfg_rdy), 0);
        goto(c + 68);
        chk("cfg_rdy_still_pending", int'(cfg_rdy), 0);
        goto(c + 69);
        chk("cfg_rdy_applied", int'(cfg_rdy), 1);
        goto(c + 71);
        chk("inj_d0_cnt1", int'(inject_en), 1);
        goto(c + 72);
        chk("inj_d0_cnt0", int'(inject_en), 1);

        // Illegal configs: D==L and L==0
        goto(c + 74);
        eq.push_back(c + 75);
        send_cfg(5, 5);
        chk("cfg_rdy_after_err", int'(cfg_rdy), 1);
        goto(c + 78);
        eq.push_back(c + 79);
        send_cfg(0, 0);

        // Back to L=16, D=2, then reset at slot_cnt=7 in domain 1
        goto(c + 82);
        push_slot(c + 85, 1'b0, 15);
        push_slot(c + 101, 1'b1, 15);
        send_cfg(16, 2);
        goto(c + 109);
        chk("pre_reset_domain", int'(domain), 1);
        chk("pre_reset_cnt", int'(slot_cnt), 7);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("async_rst_domain", int'(domain), 0);
        chk("async_rst_cnt", int'(slot_cnt), 0);
        chk("async_rst_inject_en", int'(inject_en), 0);
        chk("async_rst_cfg_rdy", int'(cfg_rdy), 1);
        step();
        rst_n = 1'b1;
        step();

        r = cyc;
        for (int k = 0; k < 6; k++)
            push_slot(r + 1 + 16 * k, (k % 2) != 0, 15);
        en = 1'b1;
        goto(r + 90);
        en = 1'b0;
`ifdef PLAB4_NET_DOMAIN_SCHED_STATS_EN
        chk("slots_d0", int'(slots_d0), 3);
        chk("slots_d1", int'(slots_d1), 3);
`endif
        step();
        step();
        chk("slot_queue_drained", sq.size(), 0);
        chk("err_queue_drained", eq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
